// File: rtl/cb_deseg.sv
// cb_deseg: receive-side code block desegmentation.
// Checks the CRC24B of each code block, strips filler and CRC bytes, and
// re-emits the transport block as a contiguous byte stream one cycle after
// each accepted input byte. size_err and framing_err are registered and
// appear alongside the output slot of the byte that triggered them.
module cb_deseg #(
   parameter int          KPLUS_BYTES  = 768,
   parameter int          KMINUS_BYTES = 760,
   parameter logic [23:0] CRC_POLY     = 24'h800063
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cfg_valid,
   input  logic [5:0] cfg_num_cb,
   input  logic [5:0] cfg_num_minus,
   input  logic [3:0] cfg_fill_bytes,
   output logic       cfg_ready,
   input  logic [7:0] cb_data,
   input  logic       cb_valid,
   input  logic       cb_start,
   input  logic       cb_size,
   output logic [7:0] tb_data,
   output logic       tb_valid,
   output logic       tb_first,
   output logic       tb_last,
   output logic       cb_done,
   output logic       cb_crc_ok,
   output logic       tb_done,
   output logic       tb_crc_err,
   output logic       size_err,
   output logic       framing_err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_RECV  = 2'd2;
   localparam logic [1:0] S_CHECK = 2'd3;

   localparam logic [9:0] KPLUS_LEN  = 10'(KPLUS_BYTES);
   localparam logic [9:0] KMINUS_LEN = 10'(KMINUS_BYTES);

   logic [1:0]  state_reg;
   logic [5:0]  num_cb_reg;
   logic [5:0]  num_minus_reg;
   logic [3:0]  fill_reg;
   logic [5:0]  idx_reg;
   logic [9:0]  byte_cnt_reg;
   logic [23:0] crc_reg;
   logic        crc_err_reg;
   logic [7:0]  tb_data_reg;
   logic        tb_valid_reg;
   logic        tb_first_reg;
   logic        tb_last_reg;
   logic        size_err_reg;
   logic        framing_err_reg;

   logic        single_cb;
   logic        exp_size;
   logic [9:0]  blk_len;
   logic [9:0]  data_len;
   logic        is_last_cb;
   logic        accept;
   logic        framing;
   logic [9:0]  pos;
   logic        filler;
   logic        fwd;
   logic        blk_end;
   logic        crc_ok;
   logic        cfg_legal;
   logic [23:0] crc_seed;
   logic [8:0][23:0] crc_stage;

   // Per-byte decode: where the incoming byte sits in the current block.
   always_comb begin
      single_cb  = (num_cb_reg == 6'd1);
      exp_size   = (idx_reg >= num_minus_reg);
      blk_len    = exp_size ? KPLUS_LEN : KMINUS_LEN;
      // A single-block TB carries its TB CRC through unchecked.
      data_len   = single_cb ? blk_len : blk_len - 10'd3;
      is_last_cb = (idx_reg == num_cb_reg - 6'd1);
      accept     = cb_valid && (((state_reg == S_WAIT) && cb_start) || (state_reg == S_RECV));
      framing    = cb_valid && cb_start && (state_reg == S_RECV) && (byte_cnt_reg != 10'd0);
      // A start flag always restarts the block at byte 0.
      pos        = cb_start ? 10'd0 : byte_cnt_reg;
      filler     = (idx_reg == 6'd0) && (pos < {6'd0, fill_reg});
      fwd        = accept && (pos < data_len) && !filler;
      blk_end    = accept && (pos == blk_len - 10'd1);
      crc_seed   = cb_start ? 24'd0 : crc_reg;
      crc_ok     = single_cb || (crc_reg == 24'd0);
      cfg_legal  = (cfg_num_cb != 6'd0) && (cfg_num_minus <= cfg_num_cb);
   end

   // Byte-wide CRC24B step, MSB of the byte first, unrolled one bit per stage.
   assign crc_stage[0] = crc_seed;
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_crc
         logic fb;
         assign fb = crc_stage[gi][23] ^ cb_data[7-gi];
         assign crc_stage[gi+1] = {crc_stage[gi][22:0], 1'b0} ^ (fb ? CRC_POLY : 24'd0);
      end
   endgenerate

   // Block sequencing: config latch, byte counting, CRC accumulation, block check.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= S_IDLE;
         num_cb_reg    <= 6'd0;
         num_minus_reg <= 6'd0;
         fill_reg      <= 4'd0;
         idx_reg       <= 6'd0;
         byte_cnt_reg  <= 10'd0;
         crc_reg       <= 24'd0;
         crc_err_reg   <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (cfg_valid && cfg_legal) begin
                  num_cb_reg    <= cfg_num_cb;
                  num_minus_reg <= cfg_num_minus;
                  fill_reg      <= cfg_fill_bytes;
                  idx_reg       <= 6'd0;
                  byte_cnt_reg  <= 10'd0;
                  crc_err_reg   <= 1'b0;
                  state_reg     <= S_WAIT;
               end
            end
            S_WAIT, S_RECV: begin
               if (accept) begin
                  crc_reg <= crc_stage[8];
                  if (blk_end) begin
                     byte_cnt_reg <= 10'd0;
                     state_reg    <= S_CHECK;
                  end else begin
                     byte_cnt_reg <= pos + 10'd1;
                     state_reg    <= S_RECV;
                  end
               end
            end
            default: begin
               if (!crc_ok) crc_err_reg <= 1'b1;
               idx_reg   <= idx_reg + 6'd1;
               state_reg <= is_last_cb ? S_IDLE : S_WAIT;
            end
         endcase
      end
   end

   // Registered output stream and error pulses, one cycle behind the input byte.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tb_data_reg     <= 8'd0;
         tb_valid_reg    <= 1'b0;
         tb_first_reg    <= 1'b0;
         tb_last_reg     <= 1'b0;
         size_err_reg    <= 1'b0;
         framing_err_reg <= 1'b0;
      end else begin
         tb_valid_reg    <= fwd;
         if (fwd) tb_data_reg <= cb_data;
         tb_first_reg    <= fwd && (idx_reg == 6'd0) && (pos == {6'd0, fill_reg});
         tb_last_reg     <= fwd && is_last_cb && (pos == data_len - 10'd1);
         size_err_reg    <= accept && cb_start && (cb_size != exp_size);
         framing_err_reg <= framing;
      end
   end

   assign cfg_ready   = (state_reg == S_IDLE);
   assign cb_done     = (state_reg == S_CHECK);
   assign cb_crc_ok   = (state_reg == S_CHECK) && crc_ok;
   assign tb_done     = (state_reg == S_CHECK) && is_last_cb;
   assign tb_crc_err  = crc_err_reg || ((state_reg == S_CHECK) && !crc_ok);
   assign tb_data     = tb_data_reg;
   assign tb_valid    = tb_valid_reg;
   assign tb_first    = tb_first_reg;
   assign tb_last     = tb_last_reg;
   assign size_err    = size_err_reg;
   assign framing_err = framing_err_reg;

endmodule

// File: tb/tb_cb_deseg.sv
// Testbench for cb_deseg with small block sizes (KPLUS=16, KMINUS=12).
// Each table row is one clock cycle: inputs plus the outputs expected
// just after that cycle's clock edge.
module tb_cb_deseg;

   logic       clk = 1'b0;
   logic       reset;
   logic       cfg_valid;
   logic [5:0] cfg_num_cb;
   logic [5:0] cfg_num_minus;
   logic [3:0] cfg_fill_bytes;
   logic       cfg_ready;
   logic [7:0] cb_data;
   logic       cb_valid;
   logic       cb_start;
   logic       cb_size;
   logic [7:0] tb_data;
   logic       tb_valid;
   logic       tb_first;
   logic       tb_last;
   logic       cb_done;
   logic       cb_crc_ok;
   logic       tb_done;
   logic       tb_crc_err;
   logic       size_err;
   logic       framing_err;

   always #5 clk = ~clk;

   cb_deseg #(.KPLUS_BYTES(16), .KMINUS_BYTES(12), .CRC_POLY(24'h800063)) dut (
      .clk(clk), .reset(reset),
      .cfg_valid(cfg_valid), .cfg_num_cb(cfg_num_cb), .cfg_num_minus(cfg_num_minus),
      .cfg_fill_bytes(cfg_fill_bytes), .cfg_ready(cfg_ready),
      .cb_data(cb_data), .cb_valid(cb_valid), .cb_start(cb_start), .cb_size(cb_size),
      .tb_data(tb_data), .tb_valid(tb_valid), .tb_first(tb_first), .tb_last(tb_last),
      .cb_done(cb_done), .cb_crc_ok(cb_crc_ok), .tb_done(tb_done), .tb_crc_err(tb_crc_err),
      .size_err(size_err), .framing_err(framing_err)
   );

   // Flag bit positions in the expected/actual vectors.
   localparam int F_RDY = 9, F_TV = 8, F_FIRST = 7, F_LAST = 6, F_DONE = 5;
   localparam int F_OK = 4, F_TDONE = 3, F_CERR = 2, F_SERR = 1, F_FERR = 0;

   typedef logic [7:0] bq_t[$];

   typedef struct {
      string      tag;
      logic       cfg_v;
      logic [5:0] cfg_c;
      logic [5:0] cfg_m;
      logic [3:0] cfg_f;
      logic       v;
      logic       s;
      logic       sz;
      logic [7:0] d;
      logic [9:0] ex;
      logic [7:0] ex_d;
   } vec_t;

   vec_t  tbl[$];
   string cur_tag;
   bit    m_busy;
   bit    m_err;
   int    checks;
   int    errors;

   bq_t sb, b0, b1, b1x;

   // CRC24B over a byte sequence, MSB first, zero initial value.
   function automatic bq_t with_crc(bq_t q);
      logic [23:0] c;
      bq_t r;
      c = 24'd0;
      r = q;
      foreach (q[k]) begin
         for (int b = 7; b >= 0; b--) begin
            logic fb;
            fb = c[23] ^ q[k][b];
            c  = {c[22:0], 1'b0};
            if (fb) c = c ^ 24'h800063;
         end
      end
      r.push_back(c[23:16]);
      r.push_back(c[15:8]);
      r.push_back(c[7:0]);
      return r;
   endfunction

   function automatic logic [9:0] base_flags();
      logic [9:0] f;
      f = 10'd0;
      f[F_RDY]  = !m_busy;
      f[F_CERR] = m_err;
      return f;
   endfunction

   task automatic add_row(input logic cv, input logic [5:0] cc, input logic [5:0] cm,
                          input logic [3:0] cf, input logic v, input logic s, input logic sz,
                          input logic [7:0] d, input logic [9:0] ex, input logic [7:0] exd);
      vec_t r;
      r.tag = cur_tag; r.cfg_v = cv; r.cfg_c = cc; r.cfg_m = cm; r.cfg_f = cf;
      r.v = v; r.s = s; r.sz = sz; r.d = d; r.ex = ex; r.ex_d = exd;
      tbl.push_back(r);
   endtask

   task automatic add_idle();
      add_row(0, 0, 0, 0, 0, 0, 0, 8'h00, base_flags(), 8'h00);
   endtask

   task automatic add_cfg(input logic [5:0] c, input logic [5:0] m, input logic [3:0] f);
      m_busy = 1'b1;
      m_err  = 1'b0;
      add_row(1, c, m, f, 0, 0, 0, 8'h00, base_flags(), 8'h00);
   endtask

   // A config strobe that must have no effect.
   task automatic add_cfg_nop(input logic [5:0] c, input logic [5:0] m, input logic [3:0] f);
      add_row(1, c, m, f, 0, 0, 0, 8'h00, base_flags(), 8'h00);
   endtask

   task automatic add_stray(input logic [7:0] d);
      add_row(0, 0, 0, 0, 1, 0, 0, d, base_flags(), 8'h00);
   endtask

   // Sends nsend bytes of block q; a complete block is followed by its CHECK idle cycle.
   task automatic add_block(input bq_t q, input logic sz, input int fill, input int dlen,
                            input bit first_blk, input bit last_blk, input bit ok,
                            input bit serr, input bit ferr, input int nsend, input int max_gap);
      for (int i = 0; i < nsend; i++) begin
         logic [9:0] ex;
         logic [7:0] exd;
         bit         fwd;
         if (i > 0 && max_gap > 0) begin
            int ng;
            ng = $urandom_range(max_gap, 0);
            for (int g = 0; g < ng; g++) add_idle();
         end
         ex  = 10'd0;
         exd = 8'h00;
         if (i == 0) begin
            ex[F_SERR] = serr;
            ex[F_FERR] = ferr;
         end
         fwd = (i >= fill) && (i < dlen);
         if (fwd) begin
            ex[F_TV]    = 1'b1;
            exd         = q[i];
            ex[F_FIRST] = first_blk && (i == fill);
            ex[F_LAST]  = last_blk && (i == dlen - 1);
         end
         if (i == q.size() - 1) begin
            ex[F_DONE]  = 1'b1;
            ex[F_OK]    = ok;
            ex[F_TDONE] = last_blk;
            if (!ok) m_err = 1'b1;
            if (last_blk) m_busy = 1'b0;
         end
         ex[F_CERR] = m_err;
         add_row(0, 0, 0, 0, 1, (i == 0), sz, q[i], ex, exd);
      end
      if (nsend == q.size()) add_idle();
   endtask

   task automatic add_two_block(input int max_gap);
      add_cfg(6'd2, 6'd1, 4'd1);
      add_block(b0, 1'b0, 1, 9, 1, 0, 1, 0, 0, 12, max_gap);
      add_block(b1, 1'b1, 0, 13, 0, 1, 1, 0, 0, 16, max_gap);
   endtask

   task automatic run_table();
      foreach (tbl[n]) begin
         logic [9:0] act;
         cfg_valid      = tbl[n].cfg_v;
         cfg_num_cb     = tbl[n].cfg_c;
         cfg_num_minus  = tbl[n].cfg_m;
         cfg_fill_bytes = tbl[n].cfg_f;
         cb_valid       = tbl[n].v;
         cb_start       = tbl[n].s;
         cb_size        = tbl[n].sz;
         cb_data        = tbl[n].d;
         @(posedge clk);
         #1;
         act = {cfg_ready, tb_valid, tb_first, tb_last, cb_done, cb_crc_ok,
                tb_done, tb_crc_err, size_err, framing_err};
         checks++;
         if (act !== tbl[n].ex || (tbl[n].ex[F_TV] && tb_data !== tbl[n].ex_d)) begin
            errors++;
            $display("FAIL %s row %0d: flags=%b data=%h, required flags=%b data=%h",
                     tbl[n].tag, n, act, tb_data, tbl[n].ex, tbl[n].ex_d);
         end else begin
            $display("ok   %s row %0d: flags=%b data=%h", tbl[n].tag, n, act, tb_data);
         end
      end
      cfg_valid = 1'b0;
      cb_valid  = 1'b0;
      cb_start  = 1'b0;
      tbl.delete();
   endtask

   task automatic check_reset_state(input string name);
      logic [17:0] act;
      act = {cfg_ready, tb_valid, tb_first, tb_last, cb_done, cb_crc_ok,
             tb_done, tb_crc_err, size_err, framing_err, tb_data};
      checks++;
      if (act !== {10'b10_0000_0000, 8'h00}) begin
         errors++;
         $display("FAIL %s: outputs=%b, required %b", name, act, {10'b10_0000_0000, 8'h00});
      end else begin
         $display("ok   %s: outputs=%b", name, act);
      end
   endtask

   initial begin
      bq_t raw;
      checks = 0;
      errors = 0;
      m_busy = 1'b0;
      m_err  = 1'b0;
      reset = 1'b0;
      cfg_valid = 1'b0; cfg_num_cb = 6'd0; cfg_num_minus = 6'd0; cfg_fill_bytes = 4'd0;
      cb_valid = 1'b0; cb_start = 1'b0; cb_size = 1'b0; cb_data = 8'h00;

      // Block contents
      sb.push_back(8'h00);
      sb.push_back(8'h00);
      for (int i = 1; i <= 14; i++) sb.push_back(8'(i));
      raw.push_back(8'h00);
      for (int i = 0; i < 8; i++) raw.push_back(8'hA0 + 8'(i));
      b0 = with_crc(raw);
      raw.delete();
      for (int i = 0; i < 13; i++) raw.push_back(8'hB0 + 8'(i));
      b1 = with_crc(raw);
      b1x = b1;
      b1x[5] = b1x[5] ^ 8'h01;

      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset_state");
      reset = 1'b1;

      cur_tag = "single";
      add_cfg(6'd1, 6'd0, 4'd2);
      add_block(sb, 1'b1, 2, 16, 1, 1, 1, 0, 0, 16, 0);

      cur_tag = "illegal_cfg";
      add_cfg_nop(6'd0, 6'd0, 4'd0);
      add_cfg_nop(6'd2, 6'd3, 4'd0);

      cur_tag = "two_block";
      add_cfg(6'd2, 6'd1, 4'd1);
      add_stray(8'h55);
      add_block(b0, 1'b0, 1, 9, 1, 0, 1, 0, 0, 12, 0);
      add_cfg_nop(6'd1, 6'd0, 4'd0);
      add_block(b1, 1'b1, 0, 13, 0, 1, 1, 0, 0, 16, 0);

      cur_tag = "crc_err";
      add_cfg(6'd2, 6'd1, 4'd1);
      add_block(b0, 1'b0, 1, 9, 1, 0, 1, 0, 0, 12, 0);
      add_block(b1x, 1'b1, 0, 13, 0, 1, 0, 0, 0, 16, 0);
      add_idle();

      cur_tag = "size_err";
      add_cfg(6'd2, 6'd1, 4'd1);
      add_block(b0, 1'b1, 1, 9, 1, 0, 1, 1, 0, 12, 0);
      add_block(b1, 1'b1, 0, 13, 0, 1, 1, 0, 0, 16, 0);

      cur_tag = "framing";
      add_cfg(6'd2, 6'd1, 4'd1);
      add_block(b0, 1'b0, 1, 9, 1, 0, 1, 0, 0, 12, 0);
      add_block(b1, 1'b1, 0, 13, 0, 1, 1, 0, 0, 6, 0);
      add_block(b1, 1'b1, 0, 13, 0, 1, 1, 0, 1, 16, 0);

      cur_tag = "gaps";
      add_two_block(3);
      run_table();

      // Reset asserted mid-block1 while a byte is on the output.
      cur_tag = "pre_reset";
      add_cfg(6'd2, 6'd1, 4'd1);
      add_block(b0, 1'b0, 1, 9, 1, 0, 1, 0, 0, 12, 0);
      add_block(b1, 1'b1, 0, 13, 0, 1, 1, 0, 0, 8, 0);
      run_table();
      reset = 1'b0;
      #1;
      check_reset_state("mid_block_reset");
      #2;
      reset = 1'b1;
      m_busy = 1'b0;
      m_err  = 1'b0;

      cur_tag = "after_reset";
      add_two_block(0);
      run_table();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cb_deseg.md
Name: cb_deseg

Overview:
- Receive-side counterpart of the code block segmentation path.
- Takes a byte-serial code block stream tagged with start and size flags, validates each block's CRC24B, discards filler bytes and CRC bytes, and reassembles the transport block as a contiguous byte stream.
- Sits after the decoder output FIFO. Reports per-block CRC status and transport-block framing status to the control layer.

Parameters:
- KPLUS_BYTES, 768: byte length of a large code block (cb_size=1), including CRC bytes.
- KMINUS_BYTES, 760: byte length of a small code block (cb_size=0), including CRC bytes.
- CRC_POLY, 24'h800063: CRC24B generator polynomial.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  per-TB configuration strobe.
- cfg_num_cb  in  6  number of code blocks C in the TB (1..63).
- cfg_num_minus  in  6  number of leading small blocks C-; must be <= C.
- cfg_fill_bytes  in  4  filler bytes F at the head of block 0.
- cfg_ready  out  1  high only in IDLE.
- cb_data  in  8  code block byte.
- cb_valid  in  1  cb_data qualifier.
- cb_start  in  1  marks the first byte of a block; valid only with cb_valid.
- cb_size  in  1  block size flag carried with the stream (1 = KPLUS).
- tb_data  out  8  reassembled TB byte.
- tb_valid  out  1  tb_data qualifier.
- tb_first  out  1  first TB byte.
- tb_last  out  1  last TB byte.
- cb_done  out  1  one-cycle pulse at the end of each block.
- cb_crc_ok  out  1  CRC result; valid while cb_done is high.
- tb_done  out  1  one-cycle pulse after the last block.
- tb_crc_err  out  1  sticky per TB: any block failed its CRC. Cleared on the next cfg accept.
- size_err  out  1  one-cycle pulse: cb_size differs from the expected size at cb_start.
- framing_err  out  1  one-cycle pulse: cb_start arrived mid-block.

Behaviour:
- Reset:
  - All outputs 0, except cfg_ready = 1.
  - FSM goes to IDLE; counters and the CRC register clear to 0.
- Config acceptance (IDLE):
  - cfg_valid with cfg_num_cb >= 1 and cfg_num_minus <= cfg_num_cb latches the config, clears tb_crc_err, and moves to WAIT_START.
  - An illegal config is ignored; the FSM stays in IDLE.
  - cfg_valid outside IDLE is ignored.
- Expected block length:
  - Block index idx < C- uses KMINUS_BYTES; otherwise KPLUS_BYTES.
  - CRC bytes: 3 when C > 1, 0 when C = 1. With C = 1 the TB CRC is passed through unchecked and cb_crc_ok = 1.
- WAIT_START:
  - cb_valid without cb_start: the byte is dropped silently.
  - cb_valid with cb_start: that byte becomes block byte 0. The CRC register is initialised to 0 and updated with the byte, and the FSM enters RECV.
  - size_err pulses if cb_size mismatches the expected size for idx. The block is still processed at the expected length.
- RECV:
  - byte_cnt (10 bits) counts bytes of the current block. Each valid byte updates the CRC by 8 bits per cycle, MSB first.
  - Filler bytes (idx = 0, byte_cnt < F) enter the CRC as received but are not forwarded.
  - Forwarded bytes are all bytes with byte_cnt < len-3 (or < len when C = 1) that are not filler.
  - The final 3 CRC bytes enter the CRC but are not forwarded.
  - Idle cycles (cb_valid = 0) are allowed anywhere and freeze all state.
- Output timing:
  - tb_data, tb_valid, tb_first and tb_last are registered, 1-cycle latency from the accepted input byte. No output backpressure.
  - tb_first marks the first forwarded byte of block 0.
  - tb_last marks the last forwarded byte of block C-1.
- Block end:
  - The cycle after the last byte of a block is accepted, the FSM enters CHECK.
  - cb_done pulses, with cb_crc_ok = (crc_reg == 0).
  - On failure, tb_crc_err is set.
  - Then idx increments. If idx was C-1, tb_done pulses in the same cycle as cb_done and the FSM returns to IDLE; otherwise it goes to WAIT_START.
- cb_start in RECV with byte_cnt != 0:
  - framing_err pulses and the partial block is abandoned: no cb_done, idx unchanged.
  - The new byte restarts the block as byte 0.
  - Bytes already forwarded are not retracted.
- A cb_valid byte arriving in the CHECK cycle is not accepted. The upstream FIFO must leave at least 1 idle cycle between blocks.
- Reset asserted mid-operation aborts immediately. No tb_done or cb_done is issued.

Test Plan (bench overrides KPLUS_BYTES=16, KMINUS_BYTES=12):
- Single block: C=1, C-=0, F=2, 16 bytes 0x00,0x00,0x01..0x0E -> 14 tb bytes 0x01..0x0E at 1-cycle latency, tb_first on 0x01, tb_last on 0x0E, cb_done with cb_crc_ok=1, tb_done in the same cycle.
- Two blocks: C=2, C-=1, F=1, block0 = 12 bytes (1 filler, 8 data, valid 3-byte CRC24B), block1 = 16 bytes (13 data, valid CRC) -> 21 bytes out, two cb_done with cb_crc_ok=1, tb_crc_err=0, tb_last on byte 21.
- CRC error: same as the two-block case with bit 0 of block1 data byte 5 flipped -> second cb_done with cb_crc_ok=0, tb_crc_err=1 at tb_done. tb_crc_err cleared by the next cfg_valid.
- Size mismatch: block0 sent with cb_size=1 while C-=1 -> size_err pulse on the start byte; the block is still consumed as 12 bytes; cb_crc_ok=1.
- Framing: cb_start reasserted at byte 6 of block1 -> framing_err pulse, idx stays 1, and a complete block1 (16 bytes) then yields cb_done and tb_done.
- Reset and gaps: reset asserted low mid-block1 -> all outputs 0 and cfg_ready=1 immediately. A random cb_valid gap pattern over the two-block case gives an output identical to the gapless run.
